mips_mc_control: RTL and testbench

- Multicycle MIPS control unit: a Moore main FSM plus a combinational ALU decoder.
- Drives every datapath select and enable, including the 2:1 selects (iord, alu_src_a, reg_dst, mem_to_reg) and the 3-input PC-source select (pc_src).
- Sits directly upstream of the datapath select/register stage.
- Consumes opcode/funct from the instruction register and the ALU zero flag.

---
 rtl/mips_mc_control_pkg.sv | 51 +++++
 rtl/mips_mc_control_if.sv | 36 +++
 rtl/mips_mc_control_alu_decoder.sv | 31 +++
 rtl/mips_mc_control.sv | 141 ++++++++++++++
 tb/tb_mips_mc_control.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_mc_control_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// Holds the FSM state encoding, ISA opcode/funct values, ALUOp and ALU control codes.
package mips_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALUC_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALUC_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUC_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUC_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUC_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUC_W-1:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_mc_control_if.sv
// Control-to-datapath bundle.
// master: control unit (consumes op/funct/zero, drives selects/enables/debug state).
// slave : datapath side (drives op/funct/zero, consumes the rest).
interface mips_mc_control_if;
  import mips_ctrl_pkg::*;

  logic [OP_W-1:0]    op;
  logic [FUNCT_W-1:0] funct;
  logic               zero;
  logic               iord;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         pc_src;
  logic               reg_dst;
  logic               mem_to_reg;
  logic [ALUC_W-1:0]  alu_control;
  logic               ir_write;
  logic               mem_write;
  logic               reg_write;
  logic               pc_en;
  logic               instr_done;
  logic               illegal_op;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  op, funct, zero,
    output iord, alu_src_a, alu_src_b, pc_src, reg_dst, mem_to_reg, alu_control,
           ir_write, mem_write, reg_write, pc_en, instr_done, illegal_op, state_o
  );

  modport slave (
    output op, funct, zero,
    input  iord, alu_src_a, alu_src_b, pc_src, reg_dst, mem_to_reg, alu_control,
           ir_write, mem_write, reg_write, pc_en, instr_done, illegal_op, state_o
  );
endinterface

// File: rtl/mips_mc_control_alu_decoder.sv
// mips_alu_decoder: combinational ALUOp/funct -> ALU control code.
// Ports: aluop_i (2), funct_i (FUNCT_W) -> alu_control_o (ALUC_W).
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_t             aluop_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output logic [ALUC_W-1:0]  alu_control_o
);

  // Unknown funct codes and the reserved ALUOp fall back to add.
  always_comb begin
    alu_control_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alu_control_o = ALU_ADD;
          FN_SUB:  alu_control_o = ALU_SUB;
          FN_AND:  alu_control_o = ALU_AND;
          FN_OR:   alu_control_o = ALU_OR;
          FN_SLT:  alu_control_o = ALU_SLT;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// mips_mc_control: multicycle MIPS main control FSM (Moore) plus ALU decoder.
// Ports: clk, rst (async active-high), bus (mips_mc_control_if.master):
//   in  op/funct/zero; out datapath selects, write enables, pc_en,
//   instr_done / illegal_op pulses and state_o for debug.
module mips_mc_control
  import mips_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  mips_mc_control_if.master       bus
);

  state_t state_q, state_d;

  logic   iord, alu_src_a, reg_dst, mem_to_reg;
  logic   ir_write, mem_write, reg_write, pc_write, branch, instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  aluop_t aluop;
  logic [ALUC_W-1:0] alu_control;

  // State register; reset drops straight into FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next-state and per-state decode; unused encodings assert nothing.
  always_comb begin
    state_d    = FETCH;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    aluop      = ALUOP_ADD;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            state_d    = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_FUNCT;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        aluop      = ALUOP_SUB;
        pc_src     = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  mips_alu_decoder u_alu_dec (
    .aluop_i       (aluop),
    .funct_i       (bus.funct),
    .alu_control_o (alu_control)
  );

  // Selects pass through; every enable/pulse is masked while reset is held.
  assign bus.iord        = iord;
  assign bus.alu_src_a   = alu_src_a;
  assign bus.alu_src_b   = alu_src_b;
  assign bus.pc_src      = pc_src;
  assign bus.reg_dst     = reg_dst;
  assign bus.mem_to_reg  = mem_to_reg;
  assign bus.alu_control = alu_control;
  assign bus.ir_write    = ir_write   & ~rst;
  assign bus.mem_write   = mem_write  & ~rst;
  assign bus.reg_write   = reg_write  & ~rst;
  assign bus.pc_en       = (pc_write | (branch & bus.zero)) & ~rst;
  assign bus.instr_done  = instr_done & ~rst;
  assign bus.illegal_op  = illegal_op & ~rst;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: directed scenarios plus a randomized
// instruction stream, compared against an instruction-level reference model.
module tb_mips_mc_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_mc_control_if bus();
  mips_mc_control dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic       iord;
    logic       a;
    logic [1:0] b;
    logic [1:0] pcs;
    logic       rd;
    logic       m2r;
    logic [2:0] aluc;
    logic       irw;
    logic       mw;
    logic       rw;
    logic       pce;
    logic       done;
    logic       ill;
  } out_t;

  int vectors = 0;
  int miscompares = 0;

  out_t obs;
  assign obs = '{bus.iord, bus.alu_src_a, bus.alu_src_b, bus.pc_src, bus.reg_dst,
                 bus.mem_to_reg, bus.alu_control, bus.ir_write, bus.mem_write,
                 bus.reg_write, bus.pc_en, bus.instr_done, bus.illegal_op};

  function automatic bit legal(logic [5:0] op);
    return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
           op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
  endfunction

  // Expected states visited from FETCH to the last state of the instruction.
  function automatic void states_of(input logic [5:0] op, output int q[$]);
    q = {0, 1};
    case (op)
      6'b100011: q = {q, 2, 3, 4};
      6'b101011: q = {q, 2, 5};
      6'b000000: q = {q, 6, 7};
      6'b001000: q = {q, 9, 10};
      6'b000100: q.push_back(8);
      6'b000010: q.push_back(11);
      default: ;
    endcase
  endfunction

  function automatic logic [2:0] alu_ref(logic [1:0] aluop, logic [5:0] fn);
    if (aluop == 2'b01) return 3'b110;
    if (aluop != 2'b10) return 3'b010;
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Output expectations for one instruction step.
  function automatic out_t model(int s, logic [5:0] op, logic [5:0] fn, logic z);
    out_t o = '0;
    logic [1:0] aluop = 2'b00;
    logic pcw = 1'b0, br = 1'b0;
    case (s)
      0:  begin o.b = 2'b01; o.irw = 1'b1; pcw = 1'b1; end
      1:  begin o.b = 2'b11; o.ill = !legal(op); end
      2:  begin o.a = 1'b1; o.b = 2'b10; end
      3:  o.iord = 1'b1;
      4:  begin o.m2r = 1'b1; o.rw = 1'b1; o.done = 1'b1; end
      5:  begin o.iord = 1'b1; o.mw = 1'b1; o.done = 1'b1; end
      6:  begin o.a = 1'b1; aluop = 2'b10; end
      7:  begin o.rd = 1'b1; o.rw = 1'b1; o.done = 1'b1; end
      8:  begin o.a = 1'b1; aluop = 2'b01; o.pcs = 2'b01; br = 1'b1; o.done = 1'b1; end
      9:  begin o.a = 1'b1; o.b = 2'b10; end
      10: begin o.rw = 1'b1; o.done = 1'b1; end
      11: begin o.pcs = 2'b10; pcw = 1'b1; o.done = 1'b1; end
      default: ;
    endcase
    o.pce  = pcw | (br & z);
    o.aluc = alu_ref(aluop, fn);
    return o;
  endfunction

  // Runs one instruction from the start of its FETCH cycle; zero is -1 for random.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zsel);
    int q[$];
    out_t e;
    states_of(op, q);
    bus.op = op;
    bus.funct = fn;
    foreach (q[i]) begin
      bus.zero = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
      @(negedge clk);
      e = model(q[i], op, fn, bus.zero);
      vectors++;
      if (bus.state_o !== 4'(q[i])) begin
        miscompares++;
        $display("FAIL state op=%b step=%0d got=%0d exp=%0d", op, i, bus.state_o, q[i]);
      end
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL outputs op=%b fn=%b state=%0d got=%h exp=%h", op, fn, q[i], obs, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    bus.op = 6'b100011; bus.funct = 6'b0; bus.zero = 1'b1;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (bus.state_o !== 4'd0 || obs.irw || obs.mw || obs.rw || obs.pce || obs.done || obs.ill) begin
        miscompares++;
        $display("FAIL reset_enables got state=%0d outs=%h exp state=0 enables=0", bus.state_o, obs);
      end
      vectors++;
      if (bus.alu_src_b !== 2'b01 || bus.iord !== 1'b0 || bus.pc_src !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_selects got b=%b iord=%b pcs=%b exp b=01 iord=0 pcs=00",
                 bus.alu_src_b, bus.iord, bus.pc_src);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    vectors++;
    if (bus.state_o !== 4'd0 || bus.ir_write !== 1'b1 || bus.pc_en !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release got state=%0d irw=%b pce=%b exp 0 1 1",
               bus.state_o, bus.ir_write, bus.pc_en);
    end
  endtask

  task automatic test_lw();       run_instr(6'b100011, 6'h15, -1); endtask
  task automatic test_rtype_slt(); run_instr(6'b000000, 6'b101010, -1); endtask
  task automatic test_beq();
    run_instr(6'b000100, 6'h00, 1);
    run_instr(6'b000100, 6'h00, 0);
  endtask
  task automatic test_illegal();  run_instr(6'b111111, 6'h00, -1); endtask

  // sw aborted by an asynchronous reset in the middle of MEMADR.
  task automatic test_async_abort();
    run_instr(6'b101011, 6'h00, -1);
    bus.op = 6'b101011;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if (bus.state_o !== 4'd2) begin
      miscompares++;
      $display("FAIL abort_precond got state=%0d exp=2", bus.state_o);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.state_o !== 4'd0 || bus.mem_write !== 1'b0 || bus.ir_write !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_immediate got state=%0d mw=%b irw=%b exp 0 0 0",
               bus.state_o, bus.mem_write, bus.ir_write);
    end
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (bus.mem_write !== 1'b0 || bus.state_o !== 4'd0) begin
        miscompares++;
        $display("FAIL abort_hold got state=%0d mw=%b exp 0 0", bus.state_o, bus.mem_write);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    run_instr(6'b101011, 6'h00, -1);
  endtask

  task automatic test_random();
    logic [5:0] ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    logic [5:0] fns[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] op, fn;
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr(op, fn, -1);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype_slt();
    test_beq();
    test_illegal();
    test_async_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
